muldiv_ctrl: RTL and testbench

Multi-cycle HI/LO execution unit for the EX stage. Accepts one MULT/MULTU/DIV/DIVU operation from the decoded ALU op, then sequences either a fixed-latency multiplier or a 32-iteration radix-2 divider. It stalls the pipeline while busy and presents the 64-bit {hi, lo} result with a one-cycle `done` pulse for the HI/LO write.

---
 rtl/muldiv_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO unit for the EX stage.
// Runs MULT/MULTU through a fixed-latency multiplier (MULT_LAT cycles) and
// DIV/DIVU through a 32-step restoring divider, stalling the pipeline while
// busy and pulsing `done` for one cycle when {hi, lo} should be written.
// Optional feature: define MULDIV_EARLY_OUT_EN to let divides with |a| < |b|
// skip the iteration loop entirely.
module muldiv_ctrl #(
    parameter int MULT_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  aluop,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // ALU op encodings for the four ops this unit acts on
    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1B;

    localparam logic [2:0] MUL_CNT_INIT = 3'(MULT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_SIGN,
        S_DONE
    } state_t;

    state_t      state_reg;
    logic [2:0]  mul_cnt_reg;
    logic [5:0]  div_cnt_reg;
    logic [31:0] op_a_reg;      // raw rs, also the divide-by-zero hi value
    logic [31:0] op_b_reg;      // raw rt, multiplier operand
    logic        sign_a_reg;    // rs negative and op is signed
    logic        sign_b_reg;    // rt negative and op is signed
    logic [31:0] dvsr_reg;      // divisor magnitude
    logic [63:0] rq_reg;        // {partial remainder, quotient}
    logic        done_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // Op decode and operand magnitudes
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        early_out;

    assign is_mul    = (aluop == ALUOP_MULT) || (aluop == ALUOP_MULTU);
    assign is_div    = (aluop == ALUOP_DIV)  || (aluop == ALUOP_DIVU);
    assign is_signed = (aluop == ALUOP_MULT) || (aluop == ALUOP_DIV);
    assign mag_a     = (is_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign mag_b     = (is_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

`ifdef MULDIV_EARLY_OUT_EN
    // Dividend smaller than divisor: quotient is 0 and remainder is |a|
    assign early_out = (mag_b != 32'd0) && (mag_a < mag_b);
`else
    assign early_out = 1'b0;
`endif

    // Multiplier: sign-extend to 64 bits so one multiply serves both flavours
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    assign ext_a = {{32{sign_a_reg}}, op_a_reg};
    assign ext_b = {{32{sign_b_reg}}, op_b_reg};
    assign prod  = ext_a * ext_b;

    // One restoring divide step: shift, trial-subtract, keep on no borrow
    logic [63:0] shifted;
    logic [32:0] diff;
    logic [63:0] div_step;

    assign shifted  = {rq_reg[62:0], 1'b0};
    assign diff     = {1'b0, shifted[63:32]} - {1'b0, dvsr_reg};
    assign div_step = diff[32] ? shifted : {diff[31:0], shifted[31:1], 1'b1};

    // Sign fix-up and divide-by-zero override applied in SIGN
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign quo    = rq_reg[31:0];
    assign rem    = rq_reg[63:32];
    assign res_lo = (dvsr_reg == 32'd0) ? 32'hFFFF_FFFF :
                    ((sign_a_reg ^ sign_b_reg) ? (~quo + 32'd1) : quo);
    assign res_hi = (dvsr_reg == 32'd0) ? op_a_reg :
                    (sign_a_reg ? (~rem + 32'd1) : rem);

    // Sequencer: state, counters, operand latches and registered results
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            mul_cnt_reg <= 3'd0;
            div_cnt_reg <= 6'd0;
            op_a_reg    <= 32'd0;
            op_b_reg    <= 32'd0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            dvsr_reg    <= 32'd0;
            rq_reg      <= 64'd0;
            done_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= S_IDLE;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start && is_mul) begin
                            op_a_reg    <= src_a;
                            op_b_reg    <= src_b;
                            sign_a_reg  <= is_signed & src_a[31];
                            sign_b_reg  <= is_signed & src_b[31];
                            mul_cnt_reg <= MUL_CNT_INIT;
                            state_reg   <= S_MUL;
                        end else if (start && is_div) begin
                            op_a_reg    <= src_a;
                            sign_a_reg  <= is_signed & src_a[31];
                            sign_b_reg  <= is_signed & src_b[31];
                            dvsr_reg    <= mag_b;
                            div_cnt_reg <= 6'd0;
                            if (early_out) begin
                                rq_reg    <= {mag_a, 32'd0};
                                state_reg <= S_SIGN;
                            end else begin
                                rq_reg    <= {32'd0, mag_a};
                                state_reg <= S_DIV;
                            end
                        end
                    end
                    S_MUL: begin
                        if (mul_cnt_reg == 3'd0) begin
                            hi_reg    <= prod[63:32];
                            lo_reg    <= prod[31:0];
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            mul_cnt_reg <= mul_cnt_reg - 3'd1;
                        end
                    end
                    S_DIV: begin
                        rq_reg      <= div_step;
                        div_cnt_reg <= div_cnt_reg + 6'd1;
                        if (div_cnt_reg == 6'd31) begin
                            state_reg <= S_SIGN;
                        end
                    end
                    S_SIGN: begin
                        hi_reg    <= res_hi;
                        lo_reg    <= res_lo;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Freeze request: combinational on start in IDLE so EX holds at once
    assign stall = resetn &
                   (((state_reg == S_IDLE) && start && (is_mul || is_div)) ||
                    (state_reg == S_MUL) || (state_reg == S_DIV) ||
                    (state_reg == S_SIGN));

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl with hand-computed expected results.
// Honours MULDIV_EARLY_OUT_EN for the small-dividend latency.
module tb_muldiv_ctrl;

    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1B;
    localparam logic [7:0] ALUOP_ADD   = 8'h20;

    localparam int MUL_LAT = 3;   // done at T+MULT_LAT+1 with MULT_LAT=2
    localparam int DIV_LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = 34;
`endif

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  aluop;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int chk_cnt = 0;
    int err_cnt = 0;

    muldiv_ctrl #(.MULT_LAT(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .aluop  (aluop),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called during cycle T (start already driven); follows the op to done
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        bit  stall_ok;
        @(negedge clk);
        check({tag, "_stall_T"}, 64'(stall), 64'd1);
        n = 0;
        stall_ok = 1'b1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!stall) stall_ok = 1'b0;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        $display("op %s: done after %0d cycles hi=%h lo=%h", tag, n, hi, lo);
        // start still high at the DONE edge must not launch a new op
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {62'd0, done, stall}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk);
        #1;
        aluop = op;
        src_a = a;
        src_b = b;
        start = 1'b1;
        wait_done(tag, exp_lat, exp_hi, exp_lo);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        aluop  = 8'h00;
        src_a  = 32'd0;
        src_b  = 32'd0;
        flush  = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_state", {hi, lo}, 64'd0);
        check("rst_ctrl", {62'd0, done, stall}, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Divide and multiply vectors
        run_op("div_m7_2",    ALUOP_DIV,   32'hFFFF_FFF9, 32'd2,          DIV_LAT,   32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_max_16", ALUOP_DIVU,  32'hFFFF_FFFF, 32'd16,         DIV_LAT,   32'h0000_000F, 32'h0FFF_FFFF);
        run_op("div_5_0",     ALUOP_DIV,   32'd5,         32'd0,          DIV_LAT,   32'h0000_0005, 32'hFFFF_FFFF);
        run_op("mult_m1_2",   ALUOP_MULT,  32'hFFFF_FFFF, 32'd2,          MUL_LAT,   32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_max_2", ALUOP_MULTU, 32'hFFFF_FFFF, 32'd2,          MUL_LAT,   32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_m1_m1",  ALUOP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  MUL_LAT,   32'h0000_0000, 32'h0000_0001);
        run_op("multu_max2",  ALUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  MUL_LAT,   32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_min_m1",  ALUOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  DIV_LAT,   32'h0000_0000, 32'h8000_0000);
        run_op("div_m7_m2",   ALUOP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE,  DIV_LAT,   32'hFFFF_FFFF, 32'h0000_0003);
        run_op("div_3_5",     ALUOP_DIV,   32'd3,         32'd5,          SMALL_LAT, 32'h0000_0003, 32'h0000_0000);
        run_op("divu_x_0",    ALUOP_DIVU,  32'h1234_5678, 32'd0,          DIV_LAT,   32'h1234_5678, 32'hFFFF_FFFF);

        // Non mul/div op is ignored
        @(posedge clk);
        #1;
        aluop = ALUOP_ADD;
        start = 1'b1;
        begin
            bit quiet = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (stall || done) quiet = 1'b0;
            end
            check("ignored_op", 64'(quiet), 64'd1);
        end
        @(posedge clk);
        #1 start = 1'b0;
        $display("op ignored_op: start with non mul/div op held 5 cycles");

        // flush and start together in IDLE: nothing starts
        @(posedge clk);
        #1;
        aluop = ALUOP_DIV;
        src_a = 32'd9;
        src_b = 32'd2;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start_stall", 64'(stall), 64'd0);
        repeat (3) @(negedge clk);
        check("flush_start_done", 64'(done), 64'd0);
        $display("op flush_start: start killed by simultaneous flush");

        // Flush at T+10 of a divide; prior result held, then a fresh DIVU
        @(posedge clk);
        #1;
        aluop = ALUOP_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hold", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        $display("op flush_div: killed at T+10, hi=%h lo=%h", hi, lo);
        run_op("divu_after_flush", ALUOP_DIVU, 32'd100, 32'd7, DIV_LAT, 32'h0000_0002, 32'h0000_000E);

        // Async reset at T+20 of a divide, start held so the op relaunches
        @(posedge clk);
        #1;
        aluop = ALUOP_DIV;
        src_a = 32'd1000;
        src_b = 32'd3;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid_ctrl", {62'd0, done, stall}, 64'd0);
        check("rst_mid_res", {hi, lo}, 64'd0);
        $display("op rst_mid: reset asserted at T+20, hi=%h lo=%h", hi, lo);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        wait_done("div_after_rst", DIV_LAT, 32'h0000_0001, 32'h0000_014D);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
